// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;

    localparam int unsigned SUB_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } sub_state_t;

endpackage

// File: rtl/serial_subtractor_fullsubtractor.sv
// Single-bit full subtractor cell: diff = a - b - borrow_in.
module fullsubtractor (
    input  logic a_i,
    input  logic b_i,
    input  logic borrow_i,
    output logic diff_o,
    output logic borrow_o
);

    assign diff_o   = a_i ^ b_i ^ borrow_i;
    assign borrow_o = (~a_i & b_i) | (~(a_i ^ b_i) & borrow_i);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB first, valid/ready on both sides.
// Optional signed-overflow flag enabled by defining SERIAL_SUBTRACTOR_OVF_EN.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = SUB_DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o,
    output logic             ovf_o,
    output logic             valid_o,
    input  logic             ready_i
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    sub_state_t       r_state;
    sub_state_t       w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_diff_sh;
    logic [WIDTH-1:0] r_diff;
    logic [CW-1:0]    r_count;
    logic             r_bw;
    logic             r_borrow;
    logic             w_d;
    logic             w_bw_next;
    logic             w_load;
    logic             w_step;
    logic             w_finish;

    assign w_load   = (r_state == IDLE) && valid_i;
    assign w_step   = (r_state == SHIFT) && (r_count != CW'(WIDTH));
    // One extra SHIFT cycle after the last bit publishes the result into DONE.
    assign w_finish = (r_state == SHIFT) && (r_count == CW'(WIDTH));

    fullsubtractor u_fullsub (
        .a_i      (r_a[0]),
        .b_i      (r_b[0]),
        .borrow_i (r_bw),
        .diff_o   (w_d),
        .borrow_o (w_bw_next)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (valid_i) w_state_next = SHIFT;
            SHIFT:   if (w_finish) w_state_next = DONE;
            DONE:    if (ready_i) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        ready_o = (r_state == IDLE);
        valid_o = (r_state == DONE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_a       <= '0;
            r_b       <= '0;
            r_diff_sh <= '0;
            r_diff    <= '0;
            r_count   <= '0;
            r_bw      <= 1'b0;
            r_borrow  <= 1'b0;
        end else if (w_load) begin
            r_a       <= a_i;
            r_b       <= b_i;
            r_diff_sh <= '0;
            r_count   <= '0;
            r_bw      <= 1'b0;
        end else if (w_step) begin
            r_a       <= r_a >> 1;
            r_b       <= r_b >> 1;
            r_diff_sh <= {w_d, r_diff_sh[WIDTH-1:1]};
            r_bw      <= w_bw_next;
            r_count   <= r_count + CW'(1);
        end else if (w_finish) begin
            r_diff   <= r_diff_sh;
            r_borrow <= r_bw;
        end
    end

    assign diff_o   = r_diff;
    assign borrow_o = r_borrow;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic r_a_msb;
    logic r_b_msb;
    logic r_ovf;

    // Operand MSBs are shifted out during SHIFT, so they are kept from load time.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_load) begin
            r_a_msb <= a_i[WIDTH-1];
            r_b_msb <= b_i[WIDTH-1];
        end else if (w_finish) begin
            r_ovf <= (r_a_msb != r_b_msb) && (r_diff_sh[WIDTH-1] != r_a_msb);
        end
    end

    assign ovf_o = r_ovf;
`else
    assign ovf_o = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8) against an arithmetic reference model.
module tb_serial_subtractor;

    localparam int unsigned W = 8;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
        int           acc;
    } exp_t;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         valid_i;
    logic         ready_o;
    logic [W-1:0] diff_o;
    logic         borrow_o;
    logic         ovf_o;
    logic         valid_o;
    logic         ready_i;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   rand_ready = 1'b0;
    bit   prev_valid = 1'b0;
    exp_t exp_q[$];
    exp_t cur;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .a_i      (a_i),
        .b_i      (b_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .diff_o   (diff_o),
        .borrow_o (borrow_o),
        .ovf_o    (ovf_o),
        .valid_o  (valid_o),
        .ready_i  (ready_i)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int acc);
        exp_t e;
        int   sa;
        int   sb;
        int   sd;
        e.d  = W'((int'(a) - int'(b)) & ((1 << W) - 1));
        e.bo = (int'(a) < int'(b));
        sa   = a[W-1] ? int'(a) - (1 << W) : int'(a);
        sb   = b[W-1] ? int'(b) - (1 << W) : int'(b);
        sd   = sa - sb;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        e.ov = (sd < -(1 << (W - 1))) || (sd > (1 << (W - 1)) - 1);
`else
        e.ov = 1'b0;
`endif
        e.acc = acc;
        return e;
    endfunction

    // Monitor: compare on each new result, then check it stays put while held.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            prev_valid = 1'b0;
        end else begin
            if (valid_o) begin
                if (!prev_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_valid", 64'(valid_o), 64'd0);
                    end else begin
                        cur = exp_q.pop_front();
                        chk("diff", 64'(diff_o), 64'(cur.d));
                        chk("borrow", 64'(borrow_o), 64'(cur.bo));
                        chk("ovf", 64'(ovf_o), 64'(cur.ov));
                        chk("latency", 64'(cyc - cur.acc), 64'(W + 1));
                    end
                end else begin
                    chk("held_diff", 64'(diff_o), 64'(cur.d));
                    chk("held_borrow", 64'(borrow_o), 64'(cur.bo));
                end
                chk("ready_o_in_done", 64'(ready_o), 64'd0);
            end
            prev_valid = valid_o;
        end
    end

    always @(negedge clk_i) begin
        if (rand_ready) ready_i = 1'($urandom_range(0, 1));
    end

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        n = 0;
        @(negedge clk_i);
        while (!ready_o && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        if (!ready_o) begin
            chk("ready_timeout", 64'(ready_o), 64'd1);
        end else begin
            a_i     = a;
            b_i     = b;
            valid_i = 1'b1;
            @(posedge clk_i);
            #1;
            exp_q.push_back(model(a, b, cyc));
            valid_i = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !ready_o) && n < 300) begin
            @(negedge clk_i);
            n++;
        end
        chk("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_diff"}, 64'(diff_o), 64'd0);
        chk({tag, "_borrow"}, 64'(borrow_o), 64'd0);
        chk({tag, "_ovf"}, 64'(ovf_o), 64'd0);
        chk({tag, "_valid"}, 64'(valid_o), 64'd0);
        chk({tag, "_ready"}, 64'(ready_o), 64'd1);
    endtask

    initial begin
        rst_ni  = 1'b0;
        a_i     = '0;
        b_i     = '0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        #1;
        chk_reset_outputs("reset");
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;

        // Directed cases.
        do_op(8'h5A, 8'h3C);
        wait_drain();
        do_op(8'h00, 8'h01);
        wait_drain();
        do_op(8'h80, 8'h01);
        wait_drain();
        do_op(8'hA7, 8'hA7);
        wait_drain();
        do_op(8'hC3, 8'h00);
        wait_drain();

        // Consumer stall for 5 cycles in DONE.
        ready_i = 1'b0;
        do_op(8'h12, 8'h34);
        for (int i = 0; i < 30 && !valid_o; i++) @(negedge clk_i);
        repeat (5) @(negedge clk_i);
        chk("stall_valid", 64'(valid_o), 64'd1);
        chk("stall_ready_o", 64'(ready_o), 64'd0);
        ready_i = 1'b1;
        wait_drain();

        // New operands offered mid-shift must be ignored.
        do_op(8'h33, 8'h11);
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        a_i     = 8'hFF;
        b_i     = 8'h00;
        valid_i = 1'b1;
        chk("shift_ready_o", 64'(ready_o), 64'd0);
        @(negedge clk_i);
        valid_i = 1'b0;
        wait_drain();

        // Abort mid-shift with async reset.
        do_op(8'h77, 8'h22);
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        chk_reset_outputs("abort");
        exp_q.delete();
        @(negedge clk_i);
        rst_ni = 1'b1;
        do_op(8'h10, 8'h10);
        wait_drain();

        // Randomized operands with random consumer back-pressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 25; i++) begin
            do_op(W'($urandom), W'($urandom));
        end
        wait_drain();
        rand_ready = 1'b0;
        ready_i    = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
